// File: rtl/conv_pkg.sv
// conv_pkg: shared types and elaboration helpers for the convolution sequencer
package conv_pkg;
  typedef enum logic [2:0] {LOAD_F, LOAD_X, COMPUTE, DRAIN, OUT} conv_state_t;
  function automatic int n_out(input int filter_n, input int x_n);
    return x_n - filter_n + 1;
  endfunction
  function automatic logic is_pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
endpackage

// File: rtl/conv_cnt.sv
// conv_cnt: up-counter with enable, sync clear and terminal-count flag; wraps to 0 past MAX
module conv_cnt #(
  parameter int W   = 2,
  parameter int MAX = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt = cnt_q;
  assign tc  = cnt_q == W'(MAX);
  // next count: clear wins, otherwise advance and wrap at the terminal value
  always_comb cnt_d = clr ? '0 : en ? (tc ? '0 : cnt_q + 1'b1) : cnt_q;
  // count register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: loads filter/sample memories, then sequences MAC windows and result handoff
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int FILTER_N    = 4,
  parameter int LG_FILTER_N = 2,
  parameter int X_N         = 8,
  parameter int LG_X_N      = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid_f,
  output logic                   s_ready_f,
  input  logic                   s_valid_x,
  output logic                   s_ready_x,
  input  logic                   new_f,
  output logic                   wr_en_f,
  output logic [LG_FILTER_N-1:0] wr_addr_f,
  output logic                   wr_en_x,
  output logic [LG_X_N-1:0]      wr_addr_x,
  output logic [LG_FILTER_N-1:0] rd_addr_f,
  output logic [LG_X_N-1:0]      rd_addr_x,
  output logic                   in_compute,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   curr_comp_done
);
  localparam int N_OUT = n_out(FILTER_N, X_N);
  if (!is_pow2(FILTER_N) || X_N < FILTER_N) begin : g_bad_params
    $error("conv_seq_ctrl: FILTER_N must be a power of two and X_N >= FILTER_N");
  end
  conv_state_t state_q, state_d;
  logic [LG_FILTER_N-1:0] f_cnt, k;
  logic [LG_X_N-1:0] x_cnt, o;
  logic f_tc, x_tc, k_tc, o_tc, f_hs, x_hs, x_done;
  assign s_ready_f      = state_q == LOAD_F;
  assign s_ready_x      = state_q == LOAD_X;
  assign in_compute     = state_q == COMPUTE;
  assign m_valid        = state_q == OUT;
  assign f_hs           = s_ready_f & s_valid_f & ~reset;
  assign x_hs           = s_ready_x & s_valid_x;
  assign x_done         = x_hs & x_tc;
  assign wr_en_f        = f_hs;
  assign wr_addr_f      = f_cnt;
  assign wr_en_x        = x_hs;
  assign wr_addr_x      = x_cnt;
  assign rd_addr_f      = in_compute ? k : '0;
  assign rd_addr_x      = in_compute ? o + LG_X_N'(k) : '0;
  assign curr_comp_done = m_valid & m_ready;
  conv_cnt #(.W(LG_FILTER_N), .MAX(FILTER_N - 1)) u_f_cnt (
    .clk(clk), .reset(reset), .en(f_hs), .clr(1'b0), .cnt(f_cnt), .tc(f_tc)
  );
  conv_cnt #(.W(LG_X_N), .MAX(X_N - 1)) u_x_cnt (
    .clk(clk), .reset(reset), .en(x_hs), .clr(1'b0), .cnt(x_cnt), .tc(x_tc)
  );
  conv_cnt #(.W(LG_FILTER_N), .MAX(FILTER_N - 1)) u_k (
    .clk(clk), .reset(reset), .en(in_compute), .clr(x_done), .cnt(k), .tc(k_tc)
  );
  conv_cnt #(.W(LG_X_N), .MAX(N_OUT - 1)) u_o (
    .clk(clk), .reset(reset), .en(curr_comp_done), .clr(x_done), .cnt(o), .tc(o_tc)
  );
  // phase sequencing: load filter, load frame, then window/drain/handoff per output
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD_F:  state_d = f_hs && f_tc ? LOAD_X : LOAD_F;
      LOAD_X:  state_d = x_done ? COMPUTE : LOAD_X;
      COMPUTE: state_d = k_tc ? DRAIN : COMPUTE;
      DRAIN:   state_d = OUT;
      OUT:     state_d = !curr_comp_done ? OUT : !o_tc ? COMPUTE : new_f ? LOAD_F : LOAD_X;
      default: state_d = LOAD_F;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= LOAD_F;
    else state_q <= state_d;
endmodule
